// File: rtl/demapper_if.sv
// Line-side byte stream into the demapper and payload byte stream out of it.
interface demapper_if;
    logic [7:0] i_frame_data;
    logic       i_frame_data_valid;
    logic [7:0] o_pyld_data;
    logic       o_pyld_data_valid;
    logic       i_pyld_ready;
    logic       o_pyld_drop;

    modport master (
        input  i_frame_data,
        input  i_frame_data_valid,
        input  i_pyld_ready,
        output o_pyld_data,
        output o_pyld_data_valid,
        output o_pyld_drop
    );

    modport slave (
        output i_frame_data,
        output i_frame_data_valid,
        output i_pyld_ready,
        input  o_pyld_data,
        input  o_pyld_data_valid,
        input  o_pyld_drop
    );
endinterface

// File: rtl/demapper.sv
// Frame aligner and payload extractor: FAS hunt, overhead strip, CRC-8 check.
module demapper #(
    parameter int unsigned COLS       = 1024,
    parameter int unsigned OH_COLS    = 4,
    parameter logic [7:0]  FAS0       = 8'hF6,
    parameter logic [7:0]  FAS1       = 8'h28,
    parameter int unsigned MISS_LIMIT = 3
) (
    input  logic       i_clk,
    input  logic       i_rst,
    demapper_if.master bus,
    output logic       o_in_sync,
    output logic       o_lof,
    output logic       o_crc_ok,
    output logic       o_crc_err,
    output logic       o_retrans_req
);
    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned MW = $clog2(MISS_LIMIT + 1);

    typedef enum logic [1:0] {HUNT, PRESYNC, SYNC} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [1:0]    row_q, row_d;
    logic [7:0]    crc_q, crc_d;
    logic [MW-1:0] miss_q, miss_d;
    logic          armed_q, armed_d;
    logic          full_q, full_d;
    logic [7:0]    prev_q;
    logic          prev_vld_q;
    logic [7:0]    pyld_q;
    logic          pyld_vld_q, pyld_vld_d;
    logic          sync_q, lof_q, lof_d;
    logic          ok_q, ok_d, err_q, err_d;

    logic [7:0] din;
    logic       vld;
    logic       fas_hit, at_fas, at_crc, at_arm, is_pyld;

    assign din = bus.i_frame_data;
    assign vld = bus.i_frame_data_valid;

    function automatic logic [7:0] crc8_step(input logic [7:0] c,
                                             input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++)
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        return r;
    endfunction

    always_comb begin
        fas_hit    = prev_vld_q && (prev_q == FAS0) && (din == FAS1);
        at_fas     = (row_q == 2'd0) && (col_q == CW'(1));
        at_crc     = (row_q == 2'd0) && (col_q == CW'(2));
        at_arm     = (row_q == 2'd0) && (col_q == CW'(OH_COLS));
        is_pyld    = (col_q >= CW'(OH_COLS));
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        crc_d      = crc_q;
        miss_d     = miss_q;
        armed_d    = armed_q;
        full_d     = full_q;
        pyld_vld_d = 1'b0;
        lof_d      = 1'b0;
        ok_d       = 1'b0;
        err_d      = 1'b0;
        if (vld) begin
            col_d = col_q + 1'b1;
            if (col_q == CW'(COLS - 1))
                row_d = row_q + 1'b1;
            if (is_pyld)
                crc_d = crc8_step(at_arm ? 8'h00 : crc_q, din);
            // Remember whether this frame began aligned; only such frames arm the check.
            if ((row_q == 2'd0) && (col_q == '0))
                full_d = (state_q == SYNC);
            unique case (state_q)
                HUNT: begin
                    if (fas_hit) begin
                        state_d = PRESYNC;
                        row_d   = 2'd0;
                        col_d   = CW'(2);
                    end
                end
                PRESYNC: begin
                    if (at_fas) begin
                        state_d = fas_hit ? SYNC : HUNT;
                        miss_d  = '0;
                        armed_d = 1'b0;
                    end
                end
                SYNC: begin
                    pyld_vld_d = is_pyld;
                    if (at_crc && armed_q) begin
                        ok_d  = (din == crc_q);
                        err_d = (din != crc_q);
                    end
                    if (at_arm && full_q)
                        armed_d = 1'b1;
                    if (at_fas) begin
                        if (fas_hit) begin
                            miss_d = '0;
                        end else if (miss_q == MW'(MISS_LIMIT - 1)) begin
                            state_d = HUNT;
                            miss_d  = '0;
                            lof_d   = 1'b1;
                        end else begin
                            miss_d = miss_q + 1'b1;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
            if (state_d != SYNC)
                armed_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q    <= HUNT;
            col_q      <= '0;
            row_q      <= '0;
            crc_q      <= '0;
            miss_q     <= '0;
            armed_q    <= 1'b0;
            full_q     <= 1'b0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            pyld_q     <= '0;
            pyld_vld_q <= 1'b0;
            sync_q     <= 1'b0;
            lof_q      <= 1'b0;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            crc_q      <= crc_d;
            miss_q     <= miss_d;
            armed_q    <= armed_d;
            full_q     <= full_d;
            if (vld) begin
                prev_q     <= din;
                prev_vld_q <= 1'b1;
            end
            if (pyld_vld_d)
                pyld_q <= din;
            pyld_vld_q <= pyld_vld_d;
            sync_q     <= (state_d == SYNC);
            lof_q      <= lof_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
        end
    end

    // The line never stalls: a byte offered while the client is not ready is lost.
    assign bus.o_pyld_data       = pyld_q;
    assign bus.o_pyld_data_valid = pyld_vld_q;
    assign bus.o_pyld_drop       = pyld_vld_q & ~bus.i_pyld_ready;

    assign o_in_sync     = sync_q;
    assign o_lof         = lof_q;
    assign o_crc_ok      = ok_q;
    assign o_crc_err     = err_q;
    assign o_retrans_req = err_q;
endmodule

// File: tb/tb_demapper.sv
// Randomised frame-stream bench for demapper with a frame-level reference model.
module tb_demapper;
  localparam int COLS = 16;
  localparam int OH   = 4;
  localparam int PL   = 4 * (COLS - OH);

  typedef struct {
    logic [7:0] d;
    int         c;
  } exp_t;

  typedef enum {M_HUNT, M_PRE, M_SYNC} mst_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_sync, lof, crc_ok, crc_err, retrans;

  demapper_if bus();

  demapper #(
    .COLS(COLS), .OH_COLS(OH), .FAS0(8'hF6),
    .FAS1(8'h28), .MISS_LIMIT(3)
  ) dut (
    .i_clk(clk),
    .i_rst(rst_n),
    .bus(bus),
    .o_in_sync(in_sync),
    .o_lof(lof),
    .o_crc_ok(crc_ok),
    .o_crc_err(crc_err),
    .o_retrans_req(retrans)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int ok_cnt = 0, err_cnt = 0, lof_cnt = 0;
  int drop_cnt = 0, bp_seen = 0;

  exp_t exp_q[$];
  exp_t e;

  mst_t       ms = M_HUNT;
  int         miss = 0;
  bit         prev_full = 0;
  logic [7:0] prev_tx_crc = 8'h00;
  logic [7:0] prev_act_crc = 8'h00;
  int         exp_ok = 0, exp_err = 0, exp_lof = 0;
  int         pay_cnt = 0;
  bit         inc_mode = 0;
  bit         gaps = 0;
  logic       nxt_rdy = 1'b1;
  int         bp_left = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] crc_of(input logic [7:0] a[PL]);
    logic [7:0] r;
    logic fb;
    r = 8'h00;
    for (int i = 0; i < PL; i++)
      for (int b = 7; b >= 0; b--) begin
        fb = r[7] ^ a[i][b];
        r = {r[6:0], 1'b0};
        if (fb) r = r ^ 8'h07;
      end
    return r;
  endfunction

  function automatic logic [7:0] rnd_nf6();
    logic [7:0] v;
    v = 8'($urandom);
    return (v == 8'hF6) ? 8'h5A : v;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.o_pyld_data_valid) begin
      check("pyld_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("pyld_data", bus.o_pyld_data, e.d);
        check("pyld_lat", cyc, e.c);
      end
      if (!bus.i_pyld_ready) bp_seen++;
    end
    if (bus.o_pyld_drop) drop_cnt++;
    if (crc_ok) ok_cnt++;
    if (crc_err) err_cnt++;
    if (lof) begin
      lof_cnt++;
      check("lof_insync", in_sync, 1'b0);
    end
    if (crc_err || retrans) check("retrans", retrans, crc_err);
  end

  task automatic drive(input logic v, input logic [7:0] d, input bit deliver);
    @(posedge clk);
    #1;
    bus.i_pyld_ready = nxt_rdy;
    nxt_rdy = 1'b1;
    bus.i_frame_data_valid = v;
    bus.i_frame_data = d;
    if (v && deliver) begin
      exp_q.push_back('{d: d, c: cyc + 1});
      if (bp_left > 0) begin
        bp_left--;
        nxt_rdy = 1'b0;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input bit deliver);
    int k;
    k = 0;
    while (gaps && $urandom_range(0, 1) == 0 && k < 8) begin
      drive(1'b0, 8'($urandom), 1'b0);
      k++;
    end
    drive(1'b1, d, deliver);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic send_frame(input bit fas_bad, input bit flip, input int stop);
    logic [7:0] p[PL];
    logic [7:0] a[PL];
    logic [7:0] b;
    bit start_sync, deliver;
    int k, n, idx;
    for (int i = 0; i < PL; i++) begin
      if (inc_mode) begin
        p[i] = pay_cnt[7:0];
        pay_cnt++;
      end else begin
        p[i] = rnd_nf6();
      end
      a[i] = p[i];
    end
    idx = $urandom_range(0, PL - 1);
    if (flip) a[idx][0] = ~a[idx][0];
    start_sync = (ms == M_SYNC);
    case (ms)
      M_HUNT: if (!fas_bad) ms = M_PRE;
      M_PRE: begin
        ms = fas_bad ? M_HUNT : M_SYNC;
        miss = 0;
      end
      default: begin
        if (!fas_bad) miss = 0;
        else begin
          miss++;
          if (miss == 3) begin
            ms = M_HUNT;
            miss = 0;
            exp_lof++;
          end
        end
      end
    endcase
    deliver = (ms == M_SYNC);
    if (deliver && start_sync && prev_full) begin
      if (prev_tx_crc == prev_act_crc) exp_ok++;
      else exp_err++;
    end
    k = 0;
    n = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < COLS; c++)
        if (stop == 0 || n < stop) begin
          if (c >= OH) begin
            b = a[k];
            k++;
          end else if (r == 0 && c == 0) b = fas_bad ? 8'h76 : 8'hF6;
          else if (r == 0 && c == 1) b = 8'h28;
          else if (r == 0 && c == 2) b = prev_tx_crc;
          else b = 8'h00;
          send_byte(b, deliver && c >= OH);
          n++;
        end
    prev_full = deliver && start_sync;
    prev_tx_crc = crc_of(p);
    prev_act_crc = crc_of(a);
    if (stop == 0) begin
      @(negedge clk);
      check("in_sync", in_sync, ms == M_SYNC);
    end
  endtask

  task automatic check_events(input string tag);
    idle(4);
    check({tag, "_ok"}, ok_cnt, exp_ok);
    check({tag, "_err"}, err_cnt, exp_err);
    check({tag, "_lof"}, lof_cnt, exp_lof);
    check({tag, "_drain"}, exp_q.size(), 0);
  endtask

  initial begin
    int d0, b0;
    bus.i_frame_data = 8'h00;
    bus.i_frame_data_valid = 1'b0;
    bus.i_pyld_ready = 1'b1;

    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      bus.i_frame_data_valid = 1'b1;
      bus.i_frame_data = 8'($urandom);
      @(negedge clk);
      check("rst_outs",
            {in_sync, lof, crc_ok, crc_err, retrans, bus.o_pyld_data_valid,
             bus.o_pyld_drop, bus.o_pyld_data}, 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) drive(1'b1, rnd_nf6(), 1'b0);
    @(negedge clk);
    check("no_fas_sync", in_sync, 1'b0);

    for (int i = 0; i < 3; i++) drive(1'b1, rnd_nf6(), 1'b0);
    drive(1'b1, 8'hF6, 1'b0);
    drive(1'b1, 8'h28, 1'b0);
    for (int i = 0; i < 70; i++) drive(1'b1, rnd_nf6(), 1'b0);
    @(negedge clk);
    check("false_fas_sync", in_sync, 1'b0);

    inc_mode = 1;
    for (int f = 0; f < 4; f++) send_frame(0, 0, 0);
    check_events("clean");

    inc_mode = 0;
    send_frame(0, 1, 0);
    send_frame(0, 0, 0);
    send_frame(0, 0, 0);
    check_events("crc_err");

    send_frame(1, 0, 0);
    send_frame(1, 0, 0);
    send_frame(0, 0, 0);
    for (int f = 0; f < 3; f++) send_frame(1, 0, 0);
    for (int f = 0; f < 4; f++) send_frame(0, 0, 0);
    check_events("fas_loss");

    gaps = 1;
    for (int f = 0; f < 4; f++) send_frame(0, 0, 0);
    gaps = 0;
    check_events("gaps");

    d0 = drop_cnt;
    b0 = bp_seen;
    bp_left = 10;
    send_frame(0, 0, 0);
    send_frame(0, 0, 0);
    check_events("bp");
    check("bp_drop_pulses", drop_cnt - d0, 10);
    check("bp_unaccepted", bp_seen - b0, 10);

    send_frame(0, 0, 2 * COLS + 8);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.i_frame_data_valid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("midrst_outs",
          {in_sync, lof, crc_ok, crc_err, retrans, bus.o_pyld_data_valid,
           bus.o_pyld_drop, bus.o_pyld_data}, 0);
    check("midrst_drain", exp_q.size(), 0);
    rst_n = 1'b1;
    ms = M_HUNT;
    miss = 0;
    prev_full = 0;
    idle(3);
    check("final_err", err_cnt, exp_err);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/demapper.md
Name: demapper

Overview:
Receive-side counterpart of the sender mapper. It accepts the deserialised line byte stream and finds frame alignment on the FAS pattern. It tracks row and column position, strips overhead, and delivers payload bytes to the client RX FIFO. It checks each frame's CRC-8 against the value carried in the next frame and flags errors, which drive the retransmission request back toward the sender.

Parameters:
COLS, 1024, bytes per row (power of 2, >= 8); frame = 4 rows x COLS bytes
OH_COLS, 4, overhead bytes at start of every row (cols 0..OH_COLS-1)
FAS0, 8'hF6, first FAS byte (row 0 col 0)
FAS1, 8'h28, second FAS byte (row 0 col 1)
MISS_LIMIT, 3, consecutive FAS misses in SYNC before loss of frame

Ports:
i_clk  in  1  clock
i_rst  in  1  reset; active-low, synchronous
i_frame_data  in  8  line byte from deserialiser
i_frame_data_valid  in  1  byte qualifier; all counters advance only on valid
o_pyld_data  out  8  payload byte to client RX FIFO
o_pyld_data_valid  out  1  payload byte valid (AXIS-style)
i_pyld_ready  in  1  client FIFO can accept
o_pyld_drop  out  1  one-cycle pulse: payload byte dropped (ready low)
o_in_sync  out  1  level: alignment FSM in SYNC
o_lof  out  1  one-cycle pulse: SYNC -> HUNT transition
o_crc_ok  out  1  one-cycle pulse: frame CRC matched
o_crc_err  out  1  one-cycle pulse: frame CRC mismatch
o_retrans_req  out  1  one-cycle pulse, coincident with o_crc_err

Behaviour:
- Reset (i_rst=0 at posedge): state=HUNT; all outputs 0; row/col counters 0; CRC accumulator 0x00; miss count 0; crc_armed=0; prev-byte register cleared/invalid.
- Frame format: row 0 col 0/1 = FAS0/FAS1. Row 0 col 2 = CRC-8 of previous frame's payload. Other overhead bytes are reserved and ignored. Cols OH_COLS..COLS-1 of rows 0..3 are payload (4*(COLS-OH_COLS) bytes/frame).
- CRC-8: poly x^8+x^2+x+1 (0x07), init 0x00, MSB-first, no reflection, no final XOR. Covers payload bytes only. The accumulator resets to 0x00 at row 0 col OH_COLS.
- Position counters: col 0..COLS-1 wraps to 0 and increments row; row 0..3 wraps. Increment only on i_frame_data_valid. Invalid cycles hold all state.
- FSM HUNT: compare previous valid byte and current valid byte. prev==FAS0 && cur==FAS1 -> PRESYNC, set position so the next valid byte is row 0 col 2. Invalid cycles between the two bytes do not break the pair.
- FSM PRESYNC: at the next row 0 col 1, check both FAS bytes (col 0 captured, col 1 current). Match -> SYNC, miss=0, crc_armed=0. Mismatch -> HUNT.
- FSM SYNC: FAS checked at every row 0 col 1. Match -> miss=0. Mismatch -> miss+1. miss reaching MISS_LIMIT -> HUNT, o_lof pulse, o_in_sync=0 the same cycle the pulse asserts.
- o_in_sync=1 is registered on the PRESYNC->SYNC transition cycle+1.
- Payload output only in SYNC: payload byte in at cycle N -> o_pyld_data/valid at N+1 (1-cycle latency, registered).
- Backpressure: i_pyld_ready is sampled with the output byte. If ready=0 the byte is dropped and o_pyld_drop pulses. No stall propagates to the line; the CRC still includes dropped bytes.
- CRC check: at row 0 col 2 in SYNC with crc_armed=1, compare the byte to the accumulator. o_crc_ok or o_crc_err (+o_retrans_req) pulses 1 cycle later.
- crc_armed is set at row 0 col OH_COLS of the first full frame in SYNC. The first CRC byte after entering SYNC is ignored.
- FAS miss in SYNC that does not cause LOF: the position counters keep free-running; payload and CRC handling continue.
- Reset mid-frame: immediate return to HUNT regardless of state; in-flight output byte discarded (valid=0).

Test Plan:
- Reset: hold i_rst=0 5 cycles with random valid data -> all outputs 0; release, no FAS sent -> o_in_sync stays 0, no o_pyld_data_valid.
- Clean stream (COLS=16 for sim): 4 frames, payload bytes incrementing from 0x00, correct CRCs, ready=1 -> o_in_sync rises after frame 2 FAS; 48 payload bytes per frame out in order, 1-cycle latency; o_crc_ok at frame 4 col 2 (+1 cycle); no o_crc_err.
- CRC error: same stream, flip bit 0 of one payload byte in frame 3 -> frame 4 row 0 col 2 gives o_crc_err and o_retrans_req for exactly 1 cycle; frame 5 check gives o_crc_ok.
- FAS loss: in SYNC, corrupt FAS0 in 2 frames then a good frame -> o_in_sync stays 1. Corrupt 3 consecutive frames -> o_lof pulse at the 3rd row 0 col 1, o_in_sync=0, payload output stops. Clean frames afterwards -> reacquire after 2 good FAS.
- False FAS and gaps: F6 28 pair inside payload while in HUNT -> PRESYNC, then mismatch -> HUNT, no output. Random i_frame_data_valid deassertion (50%) on clean stream -> identical payload sequence and o_crc_ok results.
- Backpressure/reset: i_pyld_ready=0 for 10 payload bytes -> exactly 10 o_pyld_drop pulses, CRC still ok. Assert i_rst=0 mid-row-2 -> next cycle HUNT, all outputs 0.
